// File: rtl/sim_run_pkg.sv
// Shared types and helpers for the simulation run controller.
// Optional stall watchdog is enabled by defining SIM_RUN_CTRL_STALL_WDOG_EN.
package sim_run_pkg;

  localparam int unsigned STATUS_W     = 3;
  // Upper bound on channel count accepted by popcount().
  localparam int unsigned MAX_CHANNELS = 256;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } run_state_t;

  typedef enum logic [STATUS_W-1:0] {
    StatusRunning = 3'd0,
    StatusHalt    = 3'd1,
    StatusTimeout = 3'd2,
    StatusMonErr  = 3'd3,
    StatusMemErr  = 3'd4,
    StatusStall   = 3'd5
  } run_status_t;

  // Number of set bits, widened to the retire counter width.
  function automatic logic [63:0] popcount(input logic [MAX_CHANNELS-1:0] v);
    logic [63:0] n;
    n = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      n = n + 64'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/prio_enc_lowest.sv
// Lowest-set-bit priority encoder: idx is the index of the lowest set bit of req.
module prio_enc_lowest #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: decides when and why a run ends (halt, timeout,
// monitor/memory error with drain, optional stall) and keeps end-of-run counters.
// Define SIM_RUN_CTRL_STALL_WDOG_EN to build in the no-commit stall watchdog.
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int unsigned CHANNELS       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter int unsigned STALL_CYCLES   = 10000,
  localparam int unsigned HALT_CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS-1:0]    halt,
  input  logic [CHANNELS-1:0]    commit,
  input  logic                   mon_error,
  input  logic                   mem_error,
  output logic                   finish,
  output logic [STATUS_W-1:0]    status,
  output logic [HALT_CHAN_W-1:0] halt_chan,
  output logic [63:0]            cycle_count,
  output logic [63:0]            retire_count
);

  run_state_t              state_q;
  run_status_t             status_q;
  logic                    finish_q;
  logic [HALT_CHAN_W-1:0]  halt_chan_q;
  logic [63:0]             cycle_q;
  logic [63:0]             retire_q;
  logic [31:0]             timeout_q;
  logic [31:0]             drain_q;

  logic [HALT_CHAN_W-1:0]  halt_idx;
  logic                    halt_any;
  logic [63:0]             commit_n;
  logic                    timeout_hit;
  logic                    stall_hit;

  prio_enc_lowest #(
    .WIDTH (CHANNELS),
    .IDX_W (HALT_CHAN_W)
  ) u_halt_enc (
    .req   (halt),
    .idx   (halt_idx),
    .valid (halt_any)
  );

  assign commit_n    = popcount(MAX_CHANNELS'(commit));
  assign timeout_hit = (timeout_q == 32'd0);

`ifdef SIM_RUN_CTRL_STALL_WDOG_EN
  logic [31:0] stall_q;

  // Stall fires in the cycle the commit-free run length reaches STALL_CYCLES.
  assign stall_hit = (commit == '0) &&
                     (({1'b0, stall_q} + 33'd1) >= 33'(STALL_CYCLES));

  // Consecutive commit-free RUN cycles; frozen outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == StRun) begin
      stall_q <= (commit == '0) ? stall_q + 32'd1 : '0;
    end
  end
`else
  // No watchdog: never stalls (parameter referenced only to keep it bound).
  assign stall_hit = 1'b0 && (STALL_CYCLES == 32'd0);
`endif

  // Run FSM with registered status, counters and finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      status_q    <= StatusRunning;
      finish_q    <= 1'b0;
      halt_chan_q <= '0;
      cycle_q     <= '0;
      retire_q    <= '0;
      timeout_q   <= TIMEOUT_CYCLES;
      drain_q     <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          cycle_q  <= cycle_q + 64'd1;
          retire_q <= retire_q + commit_n;
          if (!timeout_hit) begin
            timeout_q <= timeout_q - 32'd1;
          end
          if (mem_error) begin
            status_q <= StatusMemErr;
            drain_q  <= DRAIN_CYCLES;
            state_q  <= StDrain;
          end else if (mon_error) begin
            status_q <= StatusMonErr;
            drain_q  <= DRAIN_CYCLES;
            state_q  <= StDrain;
          end else if (timeout_hit) begin
            status_q <= StatusTimeout;
            finish_q <= 1'b1;
            state_q  <= StDone;
          end else if (stall_hit) begin
            status_q <= StatusStall;
            finish_q <= 1'b1;
            state_q  <= StDone;
          end else if (halt_any) begin
            status_q    <= StatusHalt;
            halt_chan_q <= halt_idx;
            finish_q    <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDrain: begin
          cycle_q <= cycle_q + 64'd1;
          // A zero drain length still spends one cycle here.
          if (drain_q <= 32'd1) begin
            finish_q <= 1'b1;
            state_q  <= StDone;
          end else begin
            drain_q <= drain_q - 32'd1;
          end
        end
        StDone: begin
        end
        default: begin
          finish_q <= 1'b1;
          state_q  <= StDone;
        end
      endcase
    end
  end

  assign finish       = finish_q;
  assign status       = status_q;
  assign halt_chan    = halt_chan_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: directed and randomized run scenarios checked against
// a cycle-indexed behavioural model of when and why a run ends.
module tb_sim_run_ctrl;

  localparam int unsigned CH    = 8;
  localparam int unsigned TO    = 100;
  localparam int unsigned DR    = 5;
  localparam int unsigned ST    = 16;
  localparam int          MAXC  = 160;

  logic        clk;
  logic        rst;
  logic [7:0]  halt;
  logic [7:0]  commit;
  logic        mon_error;
  logic        mem_error;
  logic        finish;
  logic [2:0]  status;
  logic [2:0]  halt_chan;
  logic [63:0] cycle_count;
  logic [63:0] retire_count;

  sim_run_ctrl #(
    .CHANNELS       (CH),
    .TIMEOUT_CYCLES (TO),
    .DRAIN_CYCLES   (DR),
    .STALL_CYCLES   (ST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .halt         (halt),
    .commit       (commit),
    .mon_error    (mon_error),
    .mem_error    (mem_error),
    .finish       (finish),
    .status       (status),
    .halt_chan    (halt_chan),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  int total;
  int bad;

  // Per-cycle stimulus; index k is the k-th RUN edge after reset release.
  logic [7:0] halt_s   [MAXC];
  logic [7:0] commit_s [MAXC];
  logic       mon_s    [MAXC];
  logic       mem_s    [MAXC];

  // Observed results of the last run_case.
  int          obs_fin;
  logic [2:0]  obs_status;
  logic [2:0]  obs_chan;
  logic [63:0] obs_cyc;
  logic [63:0] obs_ret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stim(input logic [7:0] c);
    for (int k = 0; k < MAXC; k++) begin
      halt_s[k]   = '0;
      commit_s[k] = c;
      mon_s[k]    = 1'b0;
      mem_s[k]    = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    halt      = '0;
    commit    = '0;
    mon_error = 1'b0;
    mem_error = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, ".finish"}, 64'(finish), 64'd0);
    check({pfx, ".status"}, 64'(status), 64'd0);
    check({pfx, ".halt_chan"}, 64'(halt_chan), 64'd0);
    check({pfx, ".cycle_count"}, cycle_count, 64'd0);
    check({pfx, ".retire_count"}, retire_count, 64'd0);
  endtask

  // Reference: walk the stimulus in cycle order applying the end-of-run rules.
  task automatic model(output int fin, output int st, output int ch,
                       output longint unsigned cyc, output longint unsigned ret);
    int run;
    int dlen;
    dlen = (DR > 0) ? int'(DR) : 1;
    run  = 0;
    fin  = -1;
    st   = 0;
    ch   = 0;
    cyc  = 0;
    ret  = 0;
    for (int k = 0; k < MAXC; k++) begin
      ret += longint'($countones(commit_s[k]));
      if (commit_s[k] == 0) run++; else run = 0;
      if (mem_s[k]) begin
        st = 4; fin = k + 1 + dlen;
      end else if (mon_s[k]) begin
        st = 3; fin = k + 1 + dlen;
      end else if (k == int'(TO)) begin
        st = 2; fin = k + 1;
`ifdef SIM_RUN_CTRL_STALL_WDOG_EN
      end else if (run >= int'(ST)) begin
        st = 5; fin = k + 1;
`endif
      end else if (halt_s[k] != 0) begin
        st = 1; fin = k + 1;
        for (int b = CH - 1; b >= 0; b--) if (halt_s[k][b]) ch = b;
      end
      if (st != 0) begin
        cyc = longint'(fin);
        break;
      end
    end
  endtask

  // Reset, drive the stimulus until finish, compare, then confirm DONE is frozen.
  task automatic run_case(input string name);
    int e_fin, e_st, e_ch;
    longint unsigned e_cyc, e_ret;
    model(e_fin, e_st, e_ch, e_cyc, e_ret);
    apply_reset();
    check_zero({name, ".rst"});
    obs_fin = -1;
    for (int c = 0; c < MAXC + 20; c++) begin
      halt      = (c < MAXC) ? halt_s[c]   : 8'h00;
      commit    = (c < MAXC) ? commit_s[c] : 8'h00;
      mon_error = (c < MAXC) ? mon_s[c]    : 1'b0;
      mem_error = (c < MAXC) ? mem_s[c]    : 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (finish === 1'b1) begin
        obs_fin = c + 1;
        break;
      end
    end
    obs_status = status;
    obs_chan   = halt_chan;
    obs_cyc    = cycle_count;
    obs_ret    = retire_count;
    check({name, ".fin_cycle"}, 64'(obs_fin), 64'(e_fin));
    check({name, ".status"}, 64'(obs_status), 64'(e_st));
    check({name, ".halt_chan"}, 64'(obs_chan), 64'(e_ch));
    check({name, ".cycle_count"}, obs_cyc, e_cyc);
    check({name, ".retire_count"}, obs_ret, e_ret);
    for (int c = 0; c < 4; c++) begin
      halt      = 8'($urandom);
      commit    = 8'($urandom);
      mon_error = 1'($urandom);
      mem_error = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    check({name, ".done_finish"}, 64'(finish), 64'd1);
    check({name, ".done_status"}, 64'(status), 64'(e_st));
    check({name, ".done_cycles"}, cycle_count, e_cyc);
    check({name, ".done_retire"}, retire_count, e_ret);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    halt      = '0;
    commit    = '0;
    mon_error = 1'b0;
    mem_error = 1'b0;
    @(negedge clk);

    // Halt on channels 2 and 5 at cycle 50.
    clear_stim(8'h81);
    halt_s[50] = 8'b0010_0100;
    run_case("halt");
    check("halt.spec_fin", 64'(obs_fin), 64'd51);
    check("halt.spec_chan", 64'(obs_chan), 64'd2);
    check("halt.spec_cyc", obs_cyc, 64'd51);

    // No events: timeout after TO RUN cycles.
    clear_stim(8'h80);
    run_case("timeout");
    check("timeout.spec_status", 64'(obs_status), 64'd2);
    check("timeout.spec_fin", 64'(obs_fin), 64'd101);

    // Monitor error then a halt during drain.
    clear_stim(8'h10);
    mon_s[20]  = 1'b1;
    halt_s[22] = 8'h08;
    run_case("mon_drain");
    check("mon_drain.spec_status", 64'(obs_status), 64'd3);
    check("mon_drain.spec_fin", 64'(obs_fin), 64'd26);

    // Simultaneous mem/mon/halt: memory error wins.
    clear_stim(8'h02);
    mem_s[10]  = 1'b1;
    mon_s[10]  = 1'b1;
    halt_s[10] = 8'h01;
    run_case("prio");
    check("prio.spec_status", 64'(obs_status), 64'd4);

    // Retire accumulation.
    clear_stim(8'h00);
    for (int k = 0; k < 10; k++) commit_s[k] = 8'h0F;
    for (int k = 10; k < 13; k++) commit_s[k] = 8'h05;
    halt_s[13] = 8'h40;
    run_case("retire");
    check("retire.spec_count", obs_ret, 64'd46);

`ifdef SIM_RUN_CTRL_STALL_WDOG_EN
    // Commits stop at cycle 30: stall ends the run.
    clear_stim(8'h00);
    for (int k = 0; k < 30; k++) commit_s[k] = 8'h01;
    run_case("stall");
    check("stall.spec_status", 64'(obs_status), 64'd5);
    check("stall.spec_fin", 64'(obs_fin), 64'd46);
`endif

    // Reset asserted mid-drain returns everything to reset values.
    clear_stim(8'h03);
    mon_s[5] = 1'b1;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      halt      = halt_s[c];
      commit    = commit_s[c];
      mon_error = mon_s[c];
      mem_error = mem_s[c];
      @(posedge clk);
      @(negedge clk);
    end
    check("middrain.pre_status", 64'(status), 64'd3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("middrain");
    rst = 1'b0;
    clear_stim(8'h11);
    halt_s[12] = 8'h80;
    run_case("restart");

    // Randomized scenarios.
    for (int n = 0; n < 10; n++) begin
      int e;
      int kind;
      clear_stim(8'h00);
      for (int k = 0; k < MAXC; k++) commit_s[k] = 8'($urandom_range(1, 255));
      e    = int'($urandom_range(3, 90));
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: halt_s[e] = 8'($urandom_range(1, 255));
        1: begin mon_s[e] = 1'b1; halt_s[e + 2] = 8'($urandom_range(1, 255)); end
        2: begin mem_s[e] = 1'b1; mon_s[e] = 1'b1; end
        3: ;
        default: begin
          halt_s[e] = 8'($urandom_range(1, 255));
          mon_s[e]  = 1'($urandom);
          mem_s[e]  = 1'($urandom);
        end
      endcase
      run_case($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
